// File: rtl/avr_cpu_pkg.sv
// Shared AVR CPU types: fetch sequencer states, NOP encoding, instruction-length decode.
// Pure declarations; no latency or backpressure of its own.
// is_two_word() is also used by avr_cpu_decode, so keep it free of fetch-specific state.
package avr_cpu_pkg;

    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_SKIP    = 2'd2,
        ST_SKIP_2W = 2'd3
    } fetch_state_t;

    localparam logic [15:0] NOP_OPCODE = 16'h0000;

    // LDS/STS: 1001_00sx_xxxx_0000, JMP/CALL: 1001_010x_xxxx_11cx
    function automatic logic is_two_word(input logic [15:0] op);
        logic lds_sts;
        logic jmp_call;
        lds_sts  = (op[15:10] == 6'b100100)  && (op[3:0] == 4'b0000);
        jmp_call = (op[15:9]  == 7'b1001010) && (op[3:2] == 2'b11);
        return lds_sts || jmp_call;
    endfunction

endpackage

// File: rtl/avr_cpu_fetch.sv
// Instruction fetch sequencer: owns the PC, drives a synchronous program memory, feeds execute.
// Latency: opcode one cycle after its address is issued; first valid opcode one cycle after reset release.
// Backpressure: stall freezes PC and memory read (pmem_en low); jump overrides stall. AVR_FETCH_SKIP2_EN: skip squashes both words of two-word ops.
module avr_cpu_fetch
    import avr_cpu_pkg::*;
#(
    parameter int          PC_WIDTH     = 11,
    parameter int unsigned RESET_VECTOR = 0
) (
    input  logic                clk,
    input  logic                rst,
    output logic [PC_WIDTH-1:0] pmem_addr,
    output logic                pmem_en,
    input  logic [15:0]         pmem_data,
    input  logic                stall,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_addr,
    input  logic                skip,
    output logic [15:0]         opcode,
    output logic                opcode_valid,
    output logic [PC_WIDTH-1:0] pc
);

    localparam logic [PC_WIDTH-1:0] RST_PC = PC_WIDTH'(RESET_VECTOR);
    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    fetch_state_t        state;
    fetch_state_t        state_nxt;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic [PC_WIDTH-1:0] fetch_pc_nxt;
    logic [PC_WIDTH-1:0] exec_pc;
    logic [PC_WIDTH-1:0] exec_pc_nxt;
    logic [PC_WIDTH-1:0] addr;
    logic                rd_en;
    logic                skip_second;

    // Only meaningful in ST_SKIP, where pmem_data holds the word being squashed.
`ifdef AVR_FETCH_SKIP2_EN
    assign skip_second = is_two_word(pmem_data);
`else
    assign skip_second = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        exec_pc_nxt  = exec_pc;
        addr         = fetch_pc;
        rd_en        = 1'b1;
        case (state)
            ST_BOOT: begin
                exec_pc_nxt  = fetch_pc;
                fetch_pc_nxt = fetch_pc + PC_ONE;
                state_nxt    = ST_RUN;
            end
            ST_RUN: begin
                if (jump) begin
                    // Target is read this cycle, so it executes next cycle with no bubble.
                    addr         = jump_addr;
                    exec_pc_nxt  = jump_addr;
                    fetch_pc_nxt = jump_addr + PC_ONE;
                end else if (stall) begin
                    rd_en = 1'b0;
                end else begin
                    exec_pc_nxt  = fetch_pc;
                    fetch_pc_nxt = fetch_pc + PC_ONE;
                    if (skip) begin
                        state_nxt = ST_SKIP;
                    end
                end
            end
            ST_SKIP: begin
                exec_pc_nxt  = fetch_pc;
                fetch_pc_nxt = fetch_pc + PC_ONE;
                state_nxt    = skip_second ? ST_SKIP_2W : ST_RUN;
            end
            ST_SKIP_2W: begin
                exec_pc_nxt  = fetch_pc;
                fetch_pc_nxt = fetch_pc + PC_ONE;
                state_nxt    = ST_RUN;
            end
            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_BOOT;
            fetch_pc <= RST_PC;
            exec_pc  <= RST_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            exec_pc  <= exec_pc_nxt;
        end
    end

    assign pmem_addr    = addr;
    assign pmem_en      = rd_en;
    assign opcode       = (state == ST_RUN) ? pmem_data : NOP_OPCODE;
    assign opcode_valid = (state == ST_RUN);
    assign pc           = exec_pc;

endmodule
